// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared definitions for the debounce_edge block.
//   - state_t               : 2-bit FSM state encoding of the debouncer
//   - DEFAULT_STABLE_CYCLES : default number of consecutive sampled edges a
//                             new level must hold before it is accepted
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } state_t;

    localparam int DEFAULT_STABLE_CYCLES = 4;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level. Adds exactly two
//   CLK edges of latency. Both flops clear asynchronously on reset.
//
// Ports
//   CLK   in  1  clock, rising edge
//   reset in  1  asynchronous, active-high reset
//   d     in  1  asynchronous input level
//   q     out 1  synchronized level
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic CLK,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debounce_edge.sv
// -----------------------------------------------------------------------------
// debounce_edge
//   Debounces a raw level D. A new level must be sampled on STABLE_CYCLES
//   consecutive rising edges before the registered output Q follows it.
//   rise/fall pulse for exactly the cycle in which Q changes.
//
//   Optional build macro: DEBOUNCE_EDGE_SYNC_EN
//     defined   -> D passes through sync_2ff first (+2 cycles latency)
//     undefined -> D is sampled directly
//
// Parameters
//   STABLE_CYCLES  consecutive sampled edges required (1..255)
//   CNT_W          stability counter width
//
// Ports
//   CLK        in  1      clock, rising edge
//   reset      in  1      asynchronous, active-high reset
//   D          in  1      raw, possibly bouncing level
//   Q          out 1      registered debounced level
//   rise       out 1      one-cycle pulse on Q 0->1
//   fall       out 1      one-cycle pulse on Q 1->0
//   state_dbg  out 2      current FSM state (observation only)
//   count_dbg  out CNT_W  current stability count (observation only)
// -----------------------------------------------------------------------------
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             D,
    output logic             Q,
    output logic             rise,
    output logic             fall,
    output state_t           state_dbg,
    output logic [CNT_W-1:0] count_dbg
);

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    // With a single required edge the first sample is already the accepting one.
    localparam bit               ONE_CYCLE  = (STABLE_CYCLES == 1);

    logic s;

`ifdef DEBOUNCE_EDGE_SYNC_EN
    sync_2ff u_sync (
        .CLK   (CLK),
        .reset (reset),
        .d     (D),
        .q     (s)
    );
`else
    assign s = D;
`endif

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic [CNT_W-1:0] count_inc;
    logic             q_n, rise_n, fall_n;

    // count only runs while checking and stays below STABLE_CYCLES there,
    // so the increment never overflows CNT_W.
    assign count_inc = count + CNT_ONE;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= STABLE_LO;
            count <= '0;
            Q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            Q     <= q_n;
            rise  <= rise_n;
            fall  <= fall_n;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        q_n     = Q;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            STABLE_LO: begin
                if (s) begin
                    if (ONE_CYCLE) begin
                        state_n = STABLE_HI;
                        count_n = '0;
                        q_n     = 1'b1;
                        rise_n  = 1'b1;
                    end else begin
                        state_n = CHECK_HI;
                        count_n = CNT_ONE;
                    end
                end
            end
            CHECK_HI: begin
                if (s) begin
                    if (count_inc == STABLE_MAX) begin
                        state_n = STABLE_HI;
                        count_n = '0;
                        q_n     = 1'b1;
                        rise_n  = 1'b1;
                    end else begin
                        count_n = count_inc;
                    end
                end else begin
                    // Bounce: abandon the check silently.
                    state_n = STABLE_LO;
                    count_n = '0;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    if (ONE_CYCLE) begin
                        state_n = STABLE_LO;
                        count_n = '0;
                        q_n     = 1'b0;
                        fall_n  = 1'b1;
                    end else begin
                        state_n = CHECK_LO;
                        count_n = CNT_ONE;
                    end
                end
            end
            CHECK_LO: begin
                if (!s) begin
                    if (count_inc == STABLE_MAX) begin
                        state_n = STABLE_LO;
                        count_n = '0;
                        q_n     = 1'b0;
                        fall_n  = 1'b1;
                    end else begin
                        count_n = count_inc;
                    end
                end else begin
                    state_n = STABLE_HI;
                    count_n = '0;
                end
            end
            default: begin
                state_n = STABLE_LO;
                count_n = '0;
            end
        endcase
    end

    assign state_dbg = state;
    assign count_dbg = count;

endmodule

// File: tb/tb_debounce_edge.sv
// -----------------------------------------------------------------------------
// tb_debounce_edge
//   Directed bench for debounce_edge with STABLE_CYCLES=4 and a 10 ns clock.
//   Expected latencies are hand-derived: the output changes on the
//   STABLE_CYCLES-th edge that samples the new level, plus two edges when
//   DEBOUNCE_EDGE_SYNC_EN is defined.
// -----------------------------------------------------------------------------
module tb_debounce_edge;
    import debounce_pkg::*;

    localparam int STABLE = 4;
    localparam int CW     = 3;
`ifdef DEBOUNCE_EDGE_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif
    localparam int LAT = STABLE + SYNC_DLY;

    logic          CLK;
    logic          reset;
    logic          D;
    logic          Q;
    logic          rise;
    logic          fall;
    state_t        state_dbg;
    logic [CW-1:0] count_dbg;

    int checks   = 0;
    int failures = 0;

    debounce_edge #(.STABLE_CYCLES(STABLE)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .D         (D),
        .Q         (Q),
        .rise      (rise),
        .fall      (fall),
        .state_dbg (state_dbg),
        .count_dbg (count_dbg)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns before looking at outputs.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic q_e,
                              input logic r_e, input logic f_e);
        check_eq({tag, ".Q"},    32'(Q),    32'(q_e));
        check_eq({tag, ".rise"}, 32'(rise), 32'(r_e));
        check_eq({tag, ".fall"}, 32'(fall), 32'(f_e));
    endtask

    initial begin
        reset = 1'b1;
        D     = 1'b0;
        #2;
        check_outs("reset_init", 1'b0, 1'b0, 1'b0);
        check_eq("reset_init.state", 32'(state_dbg), 32'(STABLE_LO));
        check_eq("reset_init.count", 32'(count_dbg), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // clean rise
        D = 1'b1;
        for (int i = 1; i < LAT; i++) begin
            tick();
            check_outs($sformatf("rise_wait%0d", i), 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_outs("rise_edge", 1'b1, 1'b1, 1'b0);
        check_eq("rise_edge.state", 32'(state_dbg), 32'(STABLE_HI));
        check_eq("rise_edge.count", 32'(count_dbg), 32'd0);
        tick();
        check_outs("rise_after", 1'b1, 1'b0, 1'b0);

        // one-edge low glitch while high: no change
        D = 1'b0;
        tick();
        D = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            check_outs($sformatf("glitch_hi%0d", i), 1'b1, 1'b0, 1'b0);
        end

        // clean fall
        D = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            tick();
            check_outs($sformatf("fall_wait%0d", i), 1'b1, 1'b0, 1'b0);
        end
        tick();
        check_outs("fall_edge", 1'b0, 1'b0, 1'b1);
        check_eq("fall_edge.state", 32'(state_dbg), 32'(STABLE_LO));
        tick();
        check_outs("fall_after", 1'b0, 1'b0, 1'b0);

        // bounce: 3 high, 1 low, then high until accepted
        D = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs($sformatf("bounce_hi%0d", i), 1'b0, 1'b0, 1'b0);
        end
        D = 1'b0;
        tick();
        check_outs("bounce_lo", 1'b0, 1'b0, 1'b0);
        D = 1'b1;
        for (int i = 1; i < LAT; i++) begin
            tick();
            check_outs($sformatf("bounce_wait%0d", i), 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_outs("bounce_rise", 1'b1, 1'b1, 1'b0);

        // asynchronous reset mid-cycle with D=1 while Q=1
        #2;
        reset = 1'b1;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 1'b0);
        check_eq("async_rst.state", 32'(state_dbg), 32'(STABLE_LO));
        check_eq("async_rst.count", 32'(count_dbg), 32'd0);
        tick();
        tick();
        check_outs("rst_held", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            tick();
            check_outs($sformatf("post_rst_wait%0d", i), 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_outs("post_rst_rise", 1'b1, 1'b1, 1'b0);

        // return low
        D = 1'b0;
        for (int i = 0; i < LAT; i++) tick();
        check_outs("settle_lo", 1'b0, 1'b0, 1'b1);
        tick();

        // reset while checking high with count=2
        D = 1'b1;
        for (int i = 0; i < SYNC_DLY + 2; i++) tick();
        check_eq("midchk.state", 32'(state_dbg), 32'(CHECK_HI));
        check_eq("midchk.count", 32'(count_dbg), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check_eq("midchk_rst.state", 32'(state_dbg), 32'(STABLE_LO));
        check_eq("midchk_rst.count", 32'(count_dbg), 32'd0);
        check_outs("midchk_rst", 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            tick();
            check_outs($sformatf("midchk_wait%0d", i), 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_outs("midchk_rise", 1'b1, 1'b1, 1'b0);
        tick();
        check_outs("midchk_after", 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
